ram_ctrl: RTL and testbench

Initiator-side controller for the team's 32x32 single-port synchronous RAM (ena / wena / 5-bit addr / 32-bit data, registered read, tri-stated data_out while ena is low). It accepts single or burst read/write requests over a valid/ready front end and sequences the RAM enable, write-enable, address and write-data pins. Read words are returned through a valid/ready response channel. It sits between a processor or bus-side agent and the RAM instance, and is the only driver of the RAM pins.

---
 rtl/ram_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ram_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: initiator-side controller for a single-port synchronous RAM with
// a registered read and a data_out that tri-states while ena is low.
// Accepts single or burst fill/read requests on a valid/ready front end,
// sequences the RAM pins, and returns read words on a valid/ready response
// channel. All outputs are registered from the next-state view of the FSM.
//
// Optional feature: define RAM_CTRL_VERIFY_EN to re-read every word of a
// write burst and compare it with the fill value (VRD/VCAP states, sticky
// wr_err). Without it, wr_err is tied low.
module ram_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              done,
    output logic              wr_err,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_RSP  = 3'd4
`ifdef RAM_CTRL_VERIFY_EN
        ,
        ST_VRD  = 3'd5,
        ST_VCAP = 3'd6
`endif
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W-1:0] cur_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_s;
    logic [DATA_W-1:0] fill_r;
    logic [DATA_W-1:0] fill_s;
    logic              accept_s;
    logic              cnt_zero_s;
    logic              rsp_hs_s;
    logic              pins_on_s;

    logic              req_ready_s;
    logic              rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_s;
    logic              rsp_last_s;
    logic              done_s;
    logic              ram_ena_s;
    logic              ram_wena_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;

`ifdef RAM_CTRL_VERIFY_EN
    logic [ADDR_W-1:0] start_r;
    logic [ADDR_W-1:0] start_s;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] len_s;
    logic              wr_err_s;

    // Any differing bit between the read-back word and the fill value.
    function automatic logic word_mismatch(input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
        return |(a ^ b);
    endfunction
`endif

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign cnt_zero_s = (cnt_r == {ADDR_W{1'b0}});
    assign rsp_hs_s   = (state_r == ST_RSP) && rsp_ready;

    // State register; reset abandons any burst and returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = req_we ? ST_WR : ST_RD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (cnt_zero_s) begin
`ifdef RAM_CTRL_VERIFY_EN
                    next_state_s = ST_VRD;
`else
                    next_state_s = ST_IDLE;
`endif
                end else begin
                    next_state_s = ST_WR;
                end
            end
            ST_RD:  next_state_s = ST_CAP;
            ST_CAP: next_state_s = ST_RSP;
            ST_RSP: begin
                if (rsp_hs_s) begin
                    next_state_s = rsp_last ? ST_IDLE : ST_RD;
                end else begin
                    next_state_s = ST_RSP;
                end
            end
`ifdef RAM_CTRL_VERIFY_EN
            ST_VRD:  next_state_s = ST_VCAP;
            ST_VCAP: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_VRD;
                end
            end
`endif
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Address/beat bookkeeping: latch on accept, step after each beat.
    always_comb begin
        cur_s  = cur_r;
        cnt_s  = cnt_r;
        fill_s = fill_r;
`ifdef RAM_CTRL_VERIFY_EN
        start_s  = start_r;
        len_s    = len_r;
        wr_err_s = wr_err;
`endif
        if (accept_s) begin
            cur_s  = req_addr;
            cnt_s  = req_len;
            fill_s = req_wdata;
`ifdef RAM_CTRL_VERIFY_EN
            start_s  = req_addr;
            len_s    = req_len;
            wr_err_s = 1'b0;
`endif
        end else if (state_r == ST_WR) begin
            if (!cnt_zero_s) begin
                cur_s = cur_r + ADDR_W'(1);
                cnt_s = cnt_r - ADDR_W'(1);
            end else begin
`ifdef RAM_CTRL_VERIFY_EN
                // Rewind to the start of the burst for the read-back pass.
                cur_s = start_r;
                cnt_s = len_r;
`else
                cur_s = cur_r;
`endif
            end
        end else if (rsp_hs_s && !rsp_last) begin
            cur_s = cur_r + ADDR_W'(1);
            cnt_s = cnt_r - ADDR_W'(1);
`ifdef RAM_CTRL_VERIFY_EN
        end else if (state_r == ST_VCAP) begin
            if (word_mismatch(ram_rdata, fill_r)) begin
                wr_err_s = 1'b1;
            end else begin
                wr_err_s = wr_err;
            end
            if (!cnt_zero_s) begin
                cur_s = cur_r + ADDR_W'(1);
                cnt_s = cnt_r - ADDR_W'(1);
            end else begin
                cur_s = cur_r;
            end
`endif
        end else begin
            cur_s = cur_r;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_r  <= {ADDR_W{1'b0}};
            cnt_r  <= {ADDR_W{1'b0}};
            fill_r <= {DATA_W{1'b0}};
`ifdef RAM_CTRL_VERIFY_EN
            start_r <= {ADDR_W{1'b0}};
            len_r   <= {ADDR_W{1'b0}};
            wr_err  <= 1'b0;
`endif
        end else begin
            cur_r  <= cur_s;
            cnt_r  <= cnt_s;
            fill_r <= fill_s;
`ifdef RAM_CTRL_VERIFY_EN
            start_r <= start_s;
            len_r   <= len_s;
            wr_err  <= wr_err_s;
`endif
        end
    end

`ifndef RAM_CTRL_VERIFY_EN
    assign wr_err = 1'b0;
`endif

    // Output decode from the state being entered, so every pin is registered.
    always_comb begin
        case (next_state_s)
            ST_WR, ST_RD, ST_CAP: pins_on_s = 1'b1;
`ifdef RAM_CTRL_VERIFY_EN
            ST_VRD, ST_VCAP:      pins_on_s = 1'b1;
`endif
            default:              pins_on_s = 1'b0;
        endcase
        ram_ena_s  = pins_on_s;
        ram_wena_s = (next_state_s == ST_WR);
        if (pins_on_s) begin
            ram_addr_s = cur_s;
        end else begin
            ram_addr_s = {ADDR_W{1'b0}};
        end
        if (next_state_s == ST_WR) begin
            ram_wdata_s = fill_s;
        end else begin
            ram_wdata_s = {DATA_W{1'b0}};
        end
        req_ready_s = (next_state_s == ST_IDLE);
        done_s      = (next_state_s == ST_IDLE) && (state_r != ST_IDLE);
        rsp_valid_s = (next_state_s == ST_RSP);
        // ena is still high during CAP, so the RAM is driving valid data here.
        if (state_r == ST_CAP) begin
            rsp_rdata_s = ram_rdata;
            rsp_last_s  = cnt_zero_s;
        end else if (next_state_s == ST_RSP) begin
            rsp_rdata_s = rsp_rdata;
            rsp_last_s  = rsp_last;
        end else begin
            rsp_rdata_s = rsp_rdata;
            rsp_last_s  = 1'b0;
        end
    end

    // Output registers; ram_ena falls asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_last  <= 1'b0;
            done      <= 1'b0;
            ram_ena   <= 1'b0;
            ram_wena  <= 1'b0;
            ram_addr  <= {ADDR_W{1'b0}};
            ram_wdata <= {DATA_W{1'b0}};
        end else begin
            req_ready <= req_ready_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rsp_rdata_s;
            rsp_last  <= rsp_last_s;
            done      <= done_s;
            ram_ena   <= ram_ena_s;
            ram_wena  <= ram_wena_s;
            ram_addr  <= ram_addr_s;
            ram_wdata <= ram_wdata_s;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed testbench for ram_ctrl with a behavioural 32x32 RAM model
// (registered read, data_out forced to zero while ena is low).
module tb_ram_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef RAM_CTRL_VERIFY_EN
    localparam int VMUL = 3;
`else
    localparam int VMUL = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_len = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready, rsp_valid, rsp_last, done, wr_err, ram_ena, ram_wena;
    logic [DW-1:0] rsp_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [0:31];
    logic [DW-1:0] dout_r = '0;
    logic          inject = 1'b0;
    logic          pre_clr = 1'b0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    int checks = 0;
    int errors = 0;
    int            wr_cyc[$];
    logic [AW-1:0] wr_adr[$];
    logic [DW-1:0] rd_words[$];
    logic          rd_lasts[$];
    int            first_vld;
    int            stall_seen;
    logic          stall_ok;

    ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .done(done), .wr_err(wr_err),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model with bench-side preload and an optional bit flip at address 3.
    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_ena) begin
            if (ram_wena) mem[ram_addr] <= (inject && ram_addr == 5'd3) ? (ram_wdata ^ 32'h0000_0100) : ram_wdata;
            else dout_r <= mem[ram_addr];
        end
    end
    assign ram_rdata = ram_ena ? dout_r : 32'h0000_0000;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
    endtask

    // Present one request for one edge; returns at #1 into cycle 1.
    task automatic send_req(input logic we, input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [DW-1:0] d);
        req_we = we; req_addr = a; req_len = l; req_wdata = d; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Run a fill burst, logging write cycles/addresses; returns in the done cycle.
    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l, input logic [DW-1:0] d, output int done_cyc);
        done_cyc = -1; wr_cyc.delete(); wr_adr.delete();
        send_req(1'b1, a, l, d);
        for (int k = 1; k <= 300; k++) begin
            if (ram_wena === 1'b1) begin wr_cyc.push_back(k); wr_adr.push_back(ram_addr); end
            if (done === 1'b1) begin done_cyc = k; break; end
            tick();
        end
    endtask

    // Run a read burst, optionally stalling rsp_ready for stall_n cycles on word stall_at.
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l, input int stall_at, input int stall_n, output int done_cyc);
        logic [DW-1:0] held;
        held = '0; done_cyc = -1; first_vld = -1; stall_seen = 0; stall_ok = 1'b1;
        rd_words.delete(); rd_lasts.delete();
        rsp_ready = 1'b1;
        send_req(1'b0, a, l, '0);
        for (int k = 1; k <= 300; k++) begin
            if (done === 1'b1) begin done_cyc = k; break; end
            if (rsp_valid === 1'b1) begin
                if (first_vld < 0) first_vld = k;
                if (rd_words.size() == stall_at && stall_seen < stall_n) begin
                    if (stall_seen == 0) held = rsp_rdata;
                    else if (rsp_rdata !== held) stall_ok = 1'b0;
                    if (ram_ena !== 1'b0) stall_ok = 1'b0;
                    stall_seen++;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready = 1'b1;
                    rd_words.push_back(rsp_rdata);
                    rd_lasts.push_back(rsp_last);
                end
            end
            tick();
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if ({ram_ena, ram_wena, ram_addr, ram_wdata} !== 39'd0) begin errors++; $display("FAIL reset_ram_pins got ena=%b wena=%b addr=%0d wdata=%h want all 0", ram_ena, ram_wena, ram_addr, ram_wdata); end
        checks++; if ({rsp_valid, rsp_last, done, wr_err} !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", {rsp_valid, rsp_last, done, wr_err}); end
    endtask

    task automatic test_single();
        int dc;
        do_write(5'd5, 5'd0, 32'hDEADBEEF, dc);
        checks++; if (dc != VMUL + 1) begin errors++; $display("FAIL single_wr_done_cycle got %0d want %0d", dc, VMUL + 1); end
        checks++; if (wr_adr.size() != 1 || wr_adr[0] !== 5'd5 || wr_cyc[0] != 1) begin errors++; $display("FAIL single_wr_beat got %0d beats want 1 beat at addr 5 cycle 1", wr_adr.size()); end
        checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wr_mem got %h want deadbeef", mem[5]); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
        do_read(5'd5, 5'd0, -1, 0, dc);
        checks++; if (rd_words.size() != 1 || rd_words[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data got %0d words first %h want 1 word deadbeef", rd_words.size(), rsp_rdata); end
        checks++; if (rd_lasts.size() != 1 || rd_lasts[0] !== 1'b1) begin errors++; $display("FAIL single_rd_last got %0d flags want last=1", rd_lasts.size()); end
        checks++; if (first_vld != 3) begin errors++; $display("FAIL single_rd_valid_cycle got %0d want 3", first_vld); end
        checks++; if (dc != 4) begin errors++; $display("FAIL single_rd_done_cycle got %0d want 4", dc); end
        tick();
    endtask

    task automatic test_wrap_burst();
        int dc;
        logic [AW-1:0] exp_a [0:3];
        exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
        do_write(5'd30, 5'd3, 32'h1234_5678, dc);
        checks++; if (dc != VMUL * 4 + 1) begin errors++; $display("FAIL wrap_wr_done_cycle got %0d want %0d", dc, VMUL * 4 + 1); end
        checks++; if (wr_adr.size() != 4) begin errors++; $display("FAIL wrap_wr_beats got %0d want 4", wr_adr.size()); end
        for (int i = 0; i < 4 && i < wr_adr.size(); i++) begin
            checks++; if (wr_adr[i] !== exp_a[i] || wr_cyc[i] != i + 1) begin errors++; $display("FAIL wrap_wr_beat%0d got addr %0d cycle %0d want addr %0d cycle %0d", i, wr_adr[i], wr_cyc[i], exp_a[i], i + 1); end
        end
        checks++; if (mem[2] !== 32'h0 || mem[1] !== 32'h1234_5678) begin errors++; $display("FAIL wrap_wr_mem got m1=%h m2=%h want 12345678 0", mem[1], mem[2]); end
        tick();
        do_read(5'd30, 5'd3, -1, 0, dc);
        checks++; if (rd_words.size() != 4) begin errors++; $display("FAIL wrap_rd_count got %0d want 4", rd_words.size()); end
        for (int i = 0; i < 4 && i < rd_words.size(); i++) begin
            checks++; if (rd_words[i] !== 32'h1234_5678 || rd_lasts[i] !== (i == 3)) begin errors++; $display("FAIL wrap_rd_word%0d got %h last %b want 12345678 last %b", i, rd_words[i], rd_lasts[i], (i == 3)); end
        end
        checks++; if (dc != 13) begin errors++; $display("FAIL wrap_rd_done_cycle got %0d want 13", dc); end
        tick();
    endtask

    task automatic test_stall_burst();
        int dc;
        int nlast;
        logic [DW-1:0] exp_w [0:31];
        for (int i = 0; i < 32; i++) begin
            exp_w[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
            preload(AW'(i), exp_w[i]);
        end
        do_read(5'd0, 5'd31, 10, 5, dc);
        checks++; if (rd_words.size() != 32) begin errors++; $display("FAIL stall_rd_count got %0d want 32", rd_words.size()); end
        for (int i = 0; i < 32 && i < rd_words.size(); i++) begin
            checks++; if (rd_words[i] !== exp_w[i]) begin errors++; $display("FAIL stall_rd_word%0d got %h want %h", i, rd_words[i], exp_w[i]); end
        end
        nlast = 0;
        foreach (rd_lasts[i]) if (rd_lasts[i] === 1'b1) nlast++;
        checks++; if (nlast != 1 || rd_lasts.size() != 32 || rd_lasts[31] !== 1'b1) begin errors++; $display("FAIL stall_rd_last got %0d last flags want exactly 1 on word 31", nlast); end
        checks++; if (stall_ok !== 1'b1 || stall_seen != 5) begin errors++; $display("FAIL stall_hold got ok=%b cycles=%0d want ok=1 cycles=5", stall_ok, stall_seen); end
        checks++; if (dc != 102) begin errors++; $display("FAIL stall_done_cycle got %0d want 102", dc); end
        tick();
    endtask

    task automatic test_back_to_back();
        int dc;
        logic busy_ok;
        req_we = 1'b1; req_addr = 5'd8; req_len = 5'd7; req_wdata = 32'h5A5A_0001; req_valid = 1'b1;
        tick();
        busy_ok = 1'b1; dc = -1;
        for (int k = 1; k <= 300; k++) begin
            if (done === 1'b1) begin dc = k; break; end
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        checks++; if (dc != VMUL * 8 + 1) begin errors++; $display("FAIL b2b_done_cycle got %0d want %0d", dc, VMUL * 8 + 1); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL b2b_busy_ready got ready high while busy want low"); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done got %b want 1", req_ready); end
        req_wdata = 32'h5A5A_0002;
        tick();
        req_valid = 1'b0;
        checks++; if (ram_wena !== 1'b1 || ram_addr !== 5'd8 || ram_wdata !== 32'h5A5A_0002 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_reaccept got wena=%b addr=%0d wdata=%h ready=%b want 1 8 5a5a0002 0", ram_wena, ram_addr, ram_wdata, req_ready); end
        dc = -1;
        for (int k = 1; k <= 300; k++) begin
            if (done === 1'b1) begin dc = k; break; end
            tick();
        end
        checks++; if (dc != VMUL * 8 + 1 || mem[15] !== 32'h5A5A_0002) begin errors++; $display("FAIL b2b_second got done cycle %0d mem15 %h want %0d 5a5a0002", dc, mem[15], VMUL * 8 + 1); end
        tick();
    endtask

    task automatic test_reset_mid();
        int dc;
        logic no_done;
        for (int i = 16; i < 24; i++) preload(AW'(i), 32'h0);
        send_req(1'b1, 5'd16, 5'd7, 32'hAAAA_5555);
        tick(); tick(); tick();
        checks++; if (ram_wena !== 1'b1 || ram_addr !== 5'd19) begin errors++; $display("FAIL rstmid_pre got wena=%b addr=%0d want 1 19", ram_wena, ram_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ram_ena !== 1'b0 || ram_wena !== 1'b0) begin errors++; $display("FAIL rstmid_ena_async got ena=%b wena=%b want 0 0", ram_ena, ram_wena); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready got %b want 1", req_ready); end
        no_done = 1'b1;
        tick(); if (done !== 1'b0) no_done = 1'b0;
        tick(); if (done !== 1'b0) no_done = 1'b0;
        #3 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); if (done !== 1'b0) no_done = 1'b0; end
        checks++; if (no_done !== 1'b1) begin errors++; $display("FAIL rstmid_no_done got a done pulse want none"); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL rstmid_wr_err got %b want 0", wr_err); end
        do_read(5'd16, 5'd0, -1, 0, dc); tick();
        checks++; if (rd_words.size() != 1 || rd_words[0] !== 32'hAAAA_5555) begin errors++; $display("FAIL rstmid_rd16 got %0d words want aaaa5555", rd_words.size()); end
        do_read(5'd18, 5'd0, -1, 0, dc); tick();
        checks++; if (rd_words.size() != 1 || rd_words[0] !== 32'hAAAA_5555) begin errors++; $display("FAIL rstmid_rd18 got %0d words want aaaa5555", rd_words.size()); end
        do_read(5'd19, 5'd0, -1, 0, dc); tick();
        checks++; if (rd_words.size() != 1 || rd_words[0] !== 32'h0) begin errors++; $display("FAIL rstmid_rd19 got %0d words want 00000000", rd_words.size()); end
    endtask

    task automatic test_verify();
        int dc;
`ifdef RAM_CTRL_VERIFY_EN
        inject = 1'b1;
        do_write(5'd0, 5'd7, 32'h0F0F_0F0F, dc);
        inject = 1'b0;
        checks++; if (dc != 25) begin errors++; $display("FAIL verify_done_cycle got %0d want 25", dc); end
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL verify_wr_err_set got %b want 1", wr_err); end
        tick();
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL verify_wr_err_sticky got %b want 1", wr_err); end
        send_req(1'b0, 5'd0, 5'd0, 32'h0);
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL verify_wr_err_clear got %b want 0", wr_err); end
        dc = -1;
        for (int k = 1; k <= 300; k++) begin
            if (done === 1'b1) begin dc = k; break; end
            tick();
        end
        checks++; if (dc != 4) begin errors++; $display("FAIL verify_rd_done_cycle got %0d want 4", dc); end
        tick();
        do_write(5'd8, 5'd3, 32'h3C3C_3C3C, dc);
        checks++; if (dc != 13 || wr_err !== 1'b0) begin errors++; $display("FAIL verify_clean got done %0d err %b want 13 0", dc, wr_err); end
        tick();
`else
        do_write(5'd0, 5'd7, 32'h0F0F_0F0F, dc);
        checks++; if (dc != 9) begin errors++; $display("FAIL noverify_done_cycle got %0d want 9", dc); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL noverify_wr_err got %b want 0", wr_err); end
        tick();
`endif
    endtask

    initial begin
        pre_clr = 1'b1;
        tick(); tick(); tick();
        pre_clr = 1'b0;
        test_reset();
        #3 rst = 1'b0;
        tick(); tick();
        test_single();
        test_wrap_burst();
        test_stall_burst();
        test_back_to_back();
        test_reset_mid();
        test_verify();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
